// File: rtl/seg_scan_display_pkg.sv
// Shared types and constants for the multi-channel 7-segment scan driver:
// display modes, converter states, glyph indices and segment patterns.
package seg_scan_display_pkg;

    typedef enum logic [1:0] {
        MODE_UDEC = 2'b00,
        MODE_SDEC = 2'b01,
        MODE_HEX  = 2'b10,
        MODE_RAW  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE
    } cvt_state_t;

    localparam int unsigned GLY_W    = 5;
    localparam int unsigned SEG_W    = 8;

    localparam logic [GLY_W-1:0] GLY_MINUS = 5'd16;
    localparam logic [GLY_W-1:0] GLY_BLANK = 5'd17;

    // Segment bit order {dp,g,f,e,d,c,b,a}; entry 15 first so index k is glyph k.
    localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };
    localparam logic [SEG_W-1:0] SEG_MINUS = 8'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    // One display digit: either a glyph index (raw=0) or a literal segment byte (raw=1).
    typedef struct packed {
        logic             raw;
        logic [SEG_W-1:0] code;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{raw: 1'b0, code: 8'(GLY_BLANK)};

endpackage

// File: rtl/seg_scan_display_if.sv
// MMIO write port and scan outputs of seg_scan_display, bundled with
// master (CPU side) and slave (display driver) views.
interface seg_scan_display_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DPC      = 4,
    parameter int unsigned CH_WIDTH = 16
);
    localparam int unsigned AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned ND = NUM_CH * DPC;

    logic                wr_en;
    logic                mode_wr;
    logic [AW-1:0]       wr_addr;
    logic [CH_WIDTH-1:0] wr_data;
    logic [1:0]          mode_data;
    logic                busy;
    logic [ND-1:0]       seg_en;
    logic [7:0]          seg_out;

    modport master (
        output wr_en, mode_wr, wr_addr, wr_data, mode_data,
        input  busy, seg_en, seg_out
    );

    modport slave (
        input  wr_en, mode_wr, wr_addr, wr_data, mode_data,
        output busy, seg_en, seg_out
    );

endinterface

// File: rtl/seg_scan_display_seg7_decode.sv
// Glyph index to 7-segment pattern: 0-F, minus, anything else blank.
module seg7_decode
    import seg_scan_display_pkg::*;
(
    input  logic [GLY_W-1:0] glyph,
    output logic [SEG_W-1:0] pattern_c
);

    always_comb begin
        pattern_c = SEG_BLANK;
        if (glyph[4] == 1'b0) begin
            pattern_c = SEG_HEX[glyph[3:0]];
        end else if (glyph == GLY_MINUS) begin
            pattern_c = SEG_MINUS;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multi-channel 7-segment scan driver: MMIO value/mode writes, one shared
// double-dabble converter, time-multiplexed digit scan. Optional build macro
// SEG_LZB_EN enables leading-zero blanking in decimal modes.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DPC      = 4,
    parameter int unsigned CH_WIDTH = 16,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              led_clk,
    input  logic              ledrst,
    seg_scan_display_if.slave bus
);

    localparam int unsigned ND   = NUM_CH * DPC;
    localparam int unsigned AW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BW   = DPC * 4;
    localparam int unsigned CW   = $clog2(CH_WIDTH + 1);
    localparam int unsigned IW   = (ND > 1) ? $clog2(ND) : 1;
    localparam int unsigned PW   = $clog2(SCAN_DIV);
    localparam int unsigned NHEX = (CH_WIDTH + 3) / 4;
    localparam int unsigned XN   = (NHEX > DPC) ? ((NHEX > 2) ? NHEX : 2) : ((DPC > 2) ? DPC : 2);
    localparam int unsigned XW   = XN * 4;

    logic [CH_WIDTH-1:0] val [NUM_CH];
    mode_t               mode [NUM_CH];
    logic [NUM_CH-1:0]   pend, pend_d;

    cvt_state_t          state, state_d;
    logic                take;
    logic                pick_any;
    logic [AW-1:0]       pick_ch;
    logic                wr_ok;

    logic [AW-1:0]       cur_ch;
    logic [CH_WIDTH-1:0] work;
    mode_t               work_mode;
    logic [CH_WIDTH-1:0] mag;
    logic                neg;
    logic                ovf;
    logic [BW-1:0]       bcd, dab;
    logic [CW-1:0]       cnt;

    digit_t              dbuf [ND];
    digit_t              store_dig [DPC];
    logic [XW-1:0]       wx;
    logic                ovf_eff;
    int                  msd;

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [ND-1:0]       en_d;
    digit_t              cur_dig;
    logic [SEG_W-1:0]    dec_pat;
    logic                busy_q;
    logic [ND-1:0]       seg_en_q;
    logic [SEG_W-1:0]    seg_out_q;

    assign wr_ok = (32'(bus.wr_addr) < NUM_CH);

    // Lowest-index pending channel wins.
    always_comb begin
        pick_any = |pend;
        pick_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) pick_ch = AW'(i);
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        take    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    take    = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = (work_mode == MODE_HEX || work_mode == MODE_RAW) ? ST_STORE : ST_SHIFT;
            ST_SHIFT: if (cnt == CW'(CH_WIDTH - 1)) state_d = ST_STORE;
            ST_STORE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A new write re-arms pend even for the channel being picked this cycle.
    always_comb begin
        pend_d = pend;
        if (take) pend_d[pick_ch] = 1'b0;
        if (wr_ok && (bus.wr_en || bus.mode_wr)) pend_d[bus.wr_addr] = 1'b1;
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            pend   <= '0;
            busy_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                val[c]  <= '0;
                mode[c] <= MODE_UDEC;
            end
        end else begin
            pend   <= pend_d;
            busy_q <= (state_d != ST_IDLE) || (|pend_d);
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ok && bus.wr_addr == AW'(c)) begin
                    if (bus.wr_en)   val[c]  <= bus.wr_data;
                    if (bus.mode_wr) mode[c] <= mode_t'(bus.mode_data);
                end
            end
        end
    end

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        dab = bcd;
        for (int d = 0; d < DPC; d++) begin
            if (dab[d*4 +: 4] >= 4'd5) dab[d*4 +: 4] = dab[d*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            cur_ch    <= '0;
            work      <= '0;
            work_mode <= MODE_UDEC;
            mag       <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            bcd       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cur_ch    <= pick_ch;
                        work      <= val[pick_ch];
                        work_mode <= mode[pick_ch];
                    end
                end
                ST_LOAD: begin
                    neg <= (work_mode == MODE_SDEC) && work[CH_WIDTH-1];
                    mag <= ((work_mode == MODE_SDEC) && work[CH_WIDTH-1]) ? (~work + 1'b1) : work;
                    // Most-negative value has no positive magnitude in range.
                    ovf <= (work_mode == MODE_SDEC) && (work == {1'b1, {(CH_WIDTH-1){1'b0}}});
                    bcd <= '0;
                    cnt <= '0;
                end
                ST_SHIFT: begin
                    bcd <= {dab[BW-2:0], mag[CH_WIDTH-1]};
                    mag <= {mag[CH_WIDTH-2:0], 1'b0};
                    ovf <= ovf | dab[BW-1];
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Glyphs for the channel being stored, computed from the finished conversion.
    always_comb begin
        wx      = XW'(work);
        ovf_eff = ovf | (neg & (bcd[BW-1 -: 4] != 4'd0));
        msd     = 0;
        for (int k = 0; k < DPC; k++) begin
            store_dig[k] = DIGIT_BLANK;
            if (bcd[k*4 +: 4] != 4'd0) msd = k;
        end
        case (work_mode)
            MODE_HEX: begin
                for (int k = 0; k < DPC; k++) begin
                    if (k < NHEX) store_dig[k].code = 8'(wx[k*4 +: 4]);
                end
            end
            MODE_RAW: store_dig[0] = '{raw: 1'b1, code: wx[7:0]};
            default: begin
                for (int k = 0; k < DPC; k++) begin
                    store_dig[k].code = 8'(bcd[k*4 +: 4]);
`ifdef SEG_LZB_EN
                    if (k > msd) store_dig[k].code = 8'(GLY_BLANK);
                    if (neg && k == msd + 1) store_dig[k].code = 8'(GLY_MINUS);
`else
                    if (neg && k == DPC - 1) store_dig[k].code = 8'(GLY_MINUS);
`endif
                    if (ovf_eff) store_dig[k].code = 8'(GLY_MINUS);
                end
            end
        endcase
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            for (int i = 0; i < ND; i++) dbuf[i] <= DIGIT_BLANK;
        end else if (state == ST_STORE) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cur_ch == AW'(c)) begin
                    for (int k = 0; k < DPC; k++) dbuf[c*DPC + k] <= store_dig[k];
                end
            end
        end
    end

    // Scan: seg_en and seg_out are both registered from the same index.
    always_comb begin
        for (int k = 0; k < ND; k++) en_d[k] = (idx == IW'(k));
        cur_dig = dbuf[idx];
    end

    seg7_decode u_decode (
        .glyph     (cur_dig.code[GLY_W-1:0]),
        .pattern_c (dec_pat)
    );

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            presc     <= '0;
            idx       <= '0;
            seg_en_q  <= '0;
            seg_out_q <= '0;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(ND - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            seg_en_q  <= en_d;
            seg_out_q <= cur_dig.raw ? cur_dig.code : dec_pat;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.seg_en  = seg_en_q;
    assign bus.seg_out = seg_out_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: directed plus random writes, expected
// digit patterns from an arithmetic reference model, popped by a scan monitor.
module tb_seg_scan_display;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned DPC      = 4;
    localparam int unsigned CH_WIDTH = 16;
    localparam int unsigned SCAN_DIV = 4;

    localparam logic [7:0] HEXPAT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    localparam logic [15:0] BND [8] = '{16'd0, 16'd9999, 16'd10000, 16'h8000,
                                        16'hFFFF, 16'hFC19, 16'hFC18, 16'h7FFF};

    logic led_clk = 1'b0;
    logic ledrst;

    seg_scan_display_if #(.NUM_CH(NUM_CH), .DPC(DPC), .CH_WIDTH(CH_WIDTH)) bus ();

    seg_scan_display #(
        .NUM_CH(NUM_CH), .DPC(DPC), .CH_WIDTH(CH_WIDTH), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .led_clk (led_clk),
        .ledrst  (ledrst),
        .bus     (bus)
    );

    always #5 led_clk = ~led_clk;

    typedef struct {
        int         dig;
        logic [7:0] pat;
    } exp_t;

    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] mval  [NUM_CH];
    logic [1:0]  mmode [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference display of one channel: digit k of the result is byte k.
    function automatic logic [31:0] expect_pats(input logic [15:0] v, input logic [1:0] m);
        logic [3:0][7:0] p;
        int  mg, avail, top, dg;
        bit  ng;
        p = '0;
        case (m)
            2'b10: for (int k = 0; k < 4; k++) p[k] = HEXPAT[v[k*4 +: 4]];
            2'b11: p[0] = v[7:0];
            default: begin
                ng    = (m == 2'b01) && v[15];
                mg    = ng ? (65536 - int'(v)) : int'(v);
                avail = ng ? 3 : 4;
                if (mg >= 10 ** avail) begin
                    for (int k = 0; k < 4; k++) p[k] = 8'h40;
                end else begin
                    top = 0;
                    for (int k = 0; k < 4; k++) begin
                        dg = (mg / (10 ** k)) % 10;
                        p[k] = HEXPAT[dg];
                        if (dg != 0) top = k;
                    end
`ifdef SEG_LZB_EN
                    for (int k = 0; k < 4; k++) if (k > top) p[k] = 8'h00;
                    if (ng) p[top + 1] = 8'h40;
`else
                    if (ng) p[3] = 8'h40;
`endif
                end
            end
        endcase
        return p;
    endfunction

    // Monitor: pop the front expectation when its digit is being driven.
    always @(negedge led_clk) begin
        if (!ledrst && sb.size() > 0) begin
            if (bus.seg_en == (8'd1 << sb[0].dig)) begin
                check($sformatf("scan ch%0d digit%0d", sb[0].dig / DPC, sb[0].dig % DPC),
                      32'(bus.seg_out), 32'(sb[0].pat));
                void'(sb.pop_front());
            end
        end
    end

    task automatic wr(input int ch, input logic [15:0] v, input logic [1:0] m, input bit dv, input bit dm);
        @(negedge led_clk);
        bus.wr_addr   = 1'(ch);
        bus.wr_data   = v;
        bus.mode_data = m;
        bus.wr_en     = dv;
        bus.mode_wr   = dm;
        if (dv) mval[ch] = v;
        if (dm) mmode[ch] = m;
        @(negedge led_clk);
        bus.wr_en   = 1'b0;
        bus.mode_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (bus.busy && n < 500) begin
            n++;
            @(negedge led_clk);
        end
        if (n >= 500) check({name, " idle timeout"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic expect_ch(input int ch);
        logic [31:0] p;
        int          t;
        repeat (2) @(negedge led_clk);
        p = expect_pats(mval[ch], mmode[ch]);
        for (int k = 0; k < DPC; k++) sb.push_back('{dig: ch * DPC + k, pat: p[k*8 +: 8]});
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            t++;
            @(negedge led_clk);
        end
        if (sb.size() > 0) begin
            check("scan drain", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wr_conv(input string name, input int ch, input logic [15:0] v, input logic [1:0] m,
                           input bit dv, input bit dm, input int lat);
        int n;
        wr(ch, v, m, dv, dm);
        wait_idle(name, n);
        if (lat > 0) check({name, " busy cycles"}, 32'(n), 32'(lat));
        expect_ch(ch);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, ch, kind, sel;
        logic [15:0] v;
        logic [1:0]  m;

        ledrst        = 1'b1;
        bus.wr_en     = 1'b0;
        bus.mode_wr   = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.mode_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mval[c]  = '0;
            mmode[c] = '0;
        end
        repeat (3) @(negedge led_clk);
        check("reset seg_en", 32'(bus.seg_en), 32'd0);
        check("reset seg_out", 32'(bus.seg_out), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        ledrst = 1'b0;

        wr_conv("udec 1234", 0, 16'd1234, 2'b00, 1'b1, 1'b1, 19);
        wr_conv("ch1 mode sdec", 1, 16'd0, 2'b01, 1'b0, 1'b1, 19);
        wr_conv("sdec -123", 1, 16'hFF85, 2'b01, 1'b1, 1'b0, 19);
        wr_conv("udec 12345", 0, 16'd12345, 2'b00, 1'b1, 1'b0, 19);
        wr_conv("ch0 mode sdec", 0, 16'd0, 2'b01, 1'b0, 1'b1, 19);
        wr_conv("sdec 0x8000", 0, 16'h8000, 2'b01, 1'b1, 1'b0, 19);
        wr_conv("ch0 mode hex", 0, 16'd0, 2'b10, 1'b0, 1'b1, 3);
        wr_conv("hex BEEF", 0, 16'hBEEF, 2'b10, 1'b1, 1'b0, 3);
        wr_conv("raw A5", 0, 16'h00A5, 2'b11, 1'b1, 1'b1, 3);

        // Back-to-back writes to one channel: the later value must end up displayed.
        @(negedge led_clk);
        bus.wr_addr = 1'b0; bus.wr_data = 16'd1111; bus.mode_data = 2'b00;
        bus.wr_en = 1'b1; bus.mode_wr = 1'b1;
        @(negedge led_clk);
        bus.wr_data = 16'd42; bus.mode_wr = 1'b0;
        mval[0] = 16'd42; mmode[0] = 2'b00;
        @(negedge led_clk);
        bus.wr_en = 1'b0;
        wait_idle("back-to-back", n);
        check("back-to-back within bound", 32'(n > 0 && n <= 38), 32'd1);
        expect_ch(0);

        // Asynchronous reset in the middle of a conversion and of the scan.
        wr(1, 16'd9999, 2'b00, 1'b1, 1'b1);
        repeat (5) @(negedge led_clk);
        #2 ledrst = 1'b1;
        #1;
        check("async reset seg_en", 32'(bus.seg_en), 32'd0);
        check("async reset seg_out", 32'(bus.seg_out), 32'd0);
        check("async reset busy", 32'(bus.busy), 32'd0);
        sb.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            mval[c]  = '0;
            mmode[c] = '0;
        end
        @(negedge led_clk);
        ledrst = 1'b0;
        repeat (3) @(negedge led_clk);
        check("no conversion after reset", 32'(bus.busy), 32'd0);
        wr_conv("cleared value", 1, 16'd0, 2'b00, 1'b0, 1'b1, 19);

        for (int it = 0; it < 40; it++) begin
            ch   = int'($urandom_range(0, NUM_CH - 1));
            kind = int'($urandom_range(0, 2));
            sel  = int'($urandom_range(0, 3));
            case (sel)
                0:       v = 16'($urandom);
                1:       v = 16'($urandom_range(0, 9999));
                2:       v = BND[$urandom_range(0, 7)];
                default: v = 16'(65536 - $urandom_range(1, 1100));
            endcase
            m = 2'($urandom_range(0, 3));
            if (kind == 0) m = mmode[ch];
            wr_conv($sformatf("rand%0d", it), ch, v, m, kind != 1, kind != 0, (m >= 2'b10) ? 3 : 19);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multi-channel 7-segment scan driver; successor to the two-channel fixed-width LED/segment block.
- CPU MMIO path writes per-channel values and display modes.
- A shared sequential binary-to-BCD converter (double-dabble) replaces combinational divide/modulo.
- Time-multiplexed scan drives one-hot digit enables and a single registered segment bus.

Parameters:
NUM_CH, 2, number of display channels
DPC, 4, digits per channel; total digits ND = NUM_CH*DPC
CH_WIDTH, 16, channel value width (two's complement in signed mode)
SCAN_DIV, 50000, led_clk cycles per digit slot (>=2)

Ports:
led_clk  in  1  clock
ledrst  in  1  reset, asynchronous, active-high
wr_en  in  1  value write strobe (one cycle per write)
mode_wr  in  1  mode write strobe
wr_addr  in  max(1,$clog2(NUM_CH))  target channel
wr_data  in  CH_WIDTH  value to display
mode_data  in  2  00 unsigned dec, 01 signed dec, 10 hex, 11 raw segments
busy  out  1  converter active or any channel pending
seg_en  out  ND  one-hot digit enable, active-high; digit k of channel c = bit c*DPC+k
seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset: all channel values, modes (00), pending flags, digit buffers, prescaler and scan index clear. Outputs seg_en=0, seg_out=0, busy=0. Reset mid-conversion aborts it with no buffer update.
- All logic runs on posedge led_clk.
- Writes:
  - wr_en latches wr_data into val[wr_addr] and sets pend[wr_addr].
  - mode_wr latches mode_data into mode[wr_addr] and sets pend[wr_addr].
  - If both strobes hit the same cycle and channel, both take effect and one pend results.
  - A wr_addr >= NUM_CH is ignored.
  - Repeated writes before conversion: last write wins.
- Converter FSM:
  - IDLE: pick the lowest-index pending channel, clear its pend, go to LOAD.
  - LOAD: compute the magnitude. Signed mode with MSB=1 gives mag = ~val+1 and neg=1. Hex/raw modes go straight to STORE.
  - SHIFT: CH_WIDTH iterations of add-3-then-shift into a DPC*4-bit BCD register plus an overflow detect bit.
  - STORE: write the channel's DPC glyph codes, then return to IDLE.
- Latency: for an idle converter, a write sampled at cycle 0 → LOAD at cycle 1 → SHIFT at cycles 2..CH_WIDTH+1 → STORE at cycle CH_WIDTH+2. Hex/raw STORE happens at cycle 2.
- busy = (state != IDLE) | (|pend).
- A write to the channel under conversion sets pend again. The in-flight result is stored, then the channel reconverts.
- Glyph rules:
  - dec: digits are LSD first.
  - signed negative: the top digit of the channel shows '-' (0x40) and the magnitude uses DPC-1 digits.
  - Overflow (mag >= 10^available digits): every digit of the channel shows '-'.
  - Most-negative value (0x8000) is treated as overflow.
  - hex: nibble k is shown on digit k, using glyphs 0-F; upper digits beyond CH_WIDTH/4 are blank.
  - raw: digit 0 shows wr_data[7:0] verbatim; other digits are blank.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - At wrap, the scan index advances 0..ND-1 and wraps to 0.
  - seg_en and seg_out are registered and update together one cycle after the index changes, so they never mismatch.

Optional Feature:
SEG_LZB_EN
- Defined: leading-zero blanking in decimal modes. Zero digits above the most significant non-zero digit are blank (0x00); digit 0 always shows. In signed-negative mode, '-' moves to the digit just above the MSD.
- Undefined: all DPC digits are shown, including leading zeros; '-' stays in the top digit.

Decomposition:
- seg_pkg: mode enum (MODE_UDEC, MODE_SDEC, MODE_HEX, MODE_RAW), glyph index constants (GLY_MINUS, GLY_BLANK), and the 7-segment pattern constants.
- Sub-module seg7_decode: combinational 5-bit glyph index to 8-bit pattern (0-F, minus, blank). Instantiated once on the scan path.

Test Plan (NUM_CH=2, DPC=4, CH_WIDTH=16, SCAN_DIV=4):
- Reset asserted mid-scan → seg_en=0, seg_out=0, busy=0 within the same cycle (asynchronous).
- Write 1234 to ch0, mode 00 → busy for 19 cycles. Scan shows seg_en=0x01 with 0x66 ('4'), 0x02 with 0x4F, 0x04 with 0x5B, 0x08 with 0x06.
- ch1 mode 01, write 0xFF85 → seg_en 0x10/0x20/0x40 show 3,2,1; seg_en 0x80 shows 0x40.
- Write 12345 to ch0, mode 00 → all of seg_en 0x01..0x08 show 0x40. With ch0 in mode 01, write 0x8000 → same result.
- ch0 mode 10, write 0xBEEF → digits show F,E,E,b = 0x71, 0x79, 0x79, 0x7C. Then mode 11, write 0x00A5 → digit 0 shows 0xA5 and digits 1-3 show 0x00.
- Write 1111 then 42 to ch0 on consecutive cycles → 42 is displayed after at most 2×(CH_WIDTH+3) cycles. With SEG_LZB_EN defined, digits 2-3 show 0x00.
